// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB3-to-AXI4-Lite bridge.
// Holds the FSM state enum, AXI response codes and the lane strobe helper.
package apb2axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_RESP,
      DONE
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Byte strobes for a 32-bit access inside a 64-bit AXI beat.
   function automatic logic [7:0] lane_strb(input logic lane);
      return lane ? 8'hF0 : 8'h0F;
   endfunction

endpackage

// File: rtl/apb2axi_lite_bridge.sv
// APB3 slave to AXI4-Lite master bridge, one transaction in flight.
// Ports: clk_i/rst_i (sync, active-high), APB3 slave (PADDR..PSLVERR),
// AXI4-Lite master channels AW, W, B, AR, R. PREADY stretches the APB
// access until the AXI response has been taken.
module apb2axi_lite_bridge
   import apb2axi_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
   input  logic [31:0]                 PWDATA,
   input  logic                        PWRITE,
   input  logic                        PSEL,
   input  logic                        PENABLE,
   output logic [31:0]                 PRDATA,
   output logic                        PREADY,
   output logic                        PSLVERR,
   output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
   output logic                        aw_valid_o,
   input  logic                        aw_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
   output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
   output logic                        w_valid_o,
   input  logic                        w_ready_i,
   input  logic [1:0]                  b_resp_i,
   input  logic                        b_valid_i,
   output logic                        b_ready_o,
   output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
   output logic                        ar_valid_o,
   input  logic                        ar_ready_i,
   input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
   input  logic [1:0]                  r_resp_i,
   input  logic                        r_valid_i,
   output logic                        r_ready_o
);

   localparam int LANES = AXI_DATA_WIDTH / 32;

   state_e                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic                      aw_valid_q, aw_valid_d;
   logic                      w_valid_q, w_valid_d;
   logic                      b_ready_q, b_ready_d;
   logic                      ar_valid_q, ar_valid_d;
   logic                      r_ready_q, r_ready_d;
   logic                      pready_q, pready_d;
   logic                      pslverr_q, pslverr_d;
   logic [31:0]               prdata_q, prdata_d;
   logic                      sel_lost_q, sel_lost_d;

   logic [AXI_ADDR_WIDTH-1:0] ext_addr;
   logic [31:0]               rd_lane;
   logic                      deliver;
   logic                      aw_done;
   logic                      w_done;

   // Word-aligned, zero-extended AXI address.
   always_comb begin
      ext_addr = '0;
      ext_addr[APB_ADDR_WIDTH-1:0] = PADDR;
      ext_addr[1:0] = 2'b00;
   end

   if (AXI_DATA_WIDTH == 64) begin : g_w64
      assign w_strb_o = lane_strb(addr_q[2]);
      assign rd_lane  = addr_q[2] ? r_data_i[63:32] : r_data_i[31:0];
   end else begin : g_w32
      assign w_strb_o = '1;
      assign rd_lane  = r_data_i[31:0];
   end

   // A master that dropped PSEL mid-transfer gets no PREADY pulse.
   assign deliver = PSEL && !sel_lost_q;
   assign aw_done = !aw_valid_q || aw_ready_i;
   assign w_done  = !w_valid_q || w_ready_i;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      b_ready_d  = b_ready_q;
      ar_valid_d = ar_valid_q;
      r_ready_d  = r_ready_q;
      pready_d   = pready_q;
      pslverr_d  = pslverr_q;
      prdata_d   = prdata_q;
      sel_lost_d = sel_lost_q;

      if (state_q != IDLE && !PSEL) sel_lost_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               addr_d     = ext_addr;
               wdata_d    = PWDATA;
               sel_lost_d = 1'b0;
               if (PWRITE) begin
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  state_d    = WR_ADDR_DATA;
               end else begin
                  ar_valid_d = 1'b1;
                  state_d    = RD_ADDR;
               end
            end
         end
         WR_ADDR_DATA: begin
            // AW and W retire independently, in either order.
            if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
            if (w_valid_q && w_ready_i) w_valid_d = 1'b0;
            if (aw_done && w_done) begin
               b_ready_d = 1'b1;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (b_valid_i) begin
               b_ready_d = 1'b0;
               pready_d  = deliver;
               pslverr_d = deliver && (b_resp_i != AXI_RESP_OKAY);
               prdata_d  = '0;
               state_d   = DONE;
            end
         end
         RD_ADDR: begin
            if (ar_ready_i) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = RD_RESP;
            end
         end
         RD_RESP: begin
            if (r_valid_i) begin
               r_ready_d = 1'b0;
               pready_d  = deliver;
               pslverr_d = deliver && (r_resp_i != AXI_RESP_OKAY);
               prdata_d  = deliver ? rd_lane : '0;
               state_d   = DONE;
            end
         end
         DONE: begin
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
         sel_lost_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         b_ready_q  <= b_ready_d;
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         sel_lost_q <= sel_lost_d;
      end
   end

   assign aw_addr_o  = addr_q;
   assign ar_addr_o  = addr_q;
   assign w_data_o   = {LANES{wdata_q}};
   assign aw_valid_o = aw_valid_q;
   assign w_valid_o  = w_valid_q;
   assign b_ready_o  = b_ready_q;
   assign ar_valid_o = ar_valid_q;
   assign r_ready_o  = r_ready_q;
   assign PREADY     = pready_q;
   assign PSLVERR    = pslverr_q;
   assign PRDATA     = prdata_q;

endmodule

// File: tb/tb_apb2axi_lite_bridge.sv
// Self-checking bench for apb2axi_lite_bridge: APB master, AXI slave
// responder and a transaction-level expectation model.
module tb_apb2axi_lite_bridge;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic [31:0] aw_addr_o, ar_addr_o;
   logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
   logic [63:0] w_data_o, r_data_i;
   logic [7:0]  w_strb_o;
   logic [1:0]  b_resp_i, r_resp_i;
   logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
   logic        r_valid_i, r_ready_o;

   always #5 clk = ~clk;

   apb2axi_lite_bridge #(
      .APB_ADDR_WIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
      .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR),
      .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o),
      .aw_ready_i(aw_ready_i),
      .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o),
      .w_ready_i(w_ready_i),
      .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
      .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o),
      .ar_ready_i(ar_ready_i),
      .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i),
      .r_ready_o(r_ready_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // expectation model: the APB transfer in progress
   bit          txn_active, exp_write, exp_no_pready;
   logic [31:0] exp_paddr, exp_pwdata, exp_prdata;
   logic        exp_err;
   int          aw_cnt, w_cnt, ar_cnt, pready_cnt, resp_wait, since_aw;
   bit          resp_done, b_fire, r_fire, aw_pend, w_pend, ar_pend;

   // slave behaviour knobs
   bit          cfg_fast, cfg_fixed;
   int          cfg_w_wait, cfg_resp_wait;
   logic [1:0]  cfg_resp;
   logic [63:0] cfg_rdata;

   logic [31:0] last_aw_addr;
   logic [63:0] last_w_data;
   logic [7:0]  last_w_strb;

   function automatic logic [31:0] axi_addr(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   function automatic logic [7:0] strb_of(input logic [31:0] a);
      return 8'(8'h0F << (4 * int'(a[2])));
   endfunction

   function automatic logic [31:0] lane_of(input logic [63:0] d,
                                           input logic [31:0] a);
      return 32'(d >> (32 * int'(a[2])));
   endfunction

   // Compare + AXI slave, once per cycle on the falling edge.
   initial begin
      logic [1:0]  resp;
      logic [63:0] data;
      aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
      b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_resp_i = 0;
      r_data_i = 0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
            b_valid_i = 0; r_valid_i = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; resp_done = 0;
            b_fire = 0; r_fire = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
         end else begin
            if (!txn_active) begin
               chk("idle", {PRDATA, PSLVERR, PREADY, aw_valid_o,
                   w_valid_o, ar_valid_o, b_ready_o, r_ready_o}, 0);
            end else begin
               if (aw_pend) chk("aw_held", aw_valid_o, 1);
               if (w_pend) chk("w_held", w_valid_o, 1);
               if (ar_pend) chk("ar_held", ar_valid_o, 1);
               if (aw_valid_o) begin
                  chk("aw_expected", exp_write && aw_cnt == 0, 1);
                  chk("aw_addr", aw_addr_o, axi_addr(exp_paddr));
               end
               if (w_valid_o) begin
                  chk("w_expected", exp_write && w_cnt == 0, 1);
                  chk("w_data", w_data_o, {exp_pwdata, exp_pwdata});
                  chk("w_strb", w_strb_o, strb_of(exp_paddr));
               end
               if (ar_valid_o) begin
                  chk("ar_expected", !exp_write && ar_cnt == 0, 1);
                  chk("ar_addr", ar_addr_o, axi_addr(exp_paddr));
               end
               if (b_ready_o)
                  chk("b_ready_order", exp_write && aw_cnt == 1 &&
                      w_cnt == 1 && !resp_done, 1);
               if (r_ready_o)
                  chk("r_ready_order", !exp_write && ar_cnt == 1 &&
                      !resp_done, 1);
               if (PREADY) begin
                  chk("pready_allowed", resp_done && !exp_no_pready &&
                      pready_cnt == 0, 1);
                  chk("prdata", PRDATA, exp_prdata);
                  chk("pslverr", PSLVERR, exp_err);
                  pready_cnt++;
               end else begin
                  chk("quiet", {PRDATA, PSLVERR}, 0);
               end
            end

            // retire responses taken at the last rising edge
            if (b_fire) begin b_valid_i = 0; b_fire = 0; end
            if (r_fire) begin r_valid_i = 0; r_fire = 0; end

            if (txn_active && !resp_done && !b_valid_i && !r_valid_i &&
                (exp_write ? (aw_cnt == 1 && w_cnt == 1) : (ar_cnt == 1)))
            begin
               if (resp_wait > 0) begin
                  resp_wait--;
               end else begin
                  if (cfg_fixed) resp = cfg_resp;
                  else resp = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
                  exp_err = (resp != 2'b00);
                  if (exp_write) begin
                     b_resp_i = resp; b_valid_i = 1; exp_prdata = 0;
                  end else begin
                     data = cfg_fixed ? cfg_rdata : {$urandom, $urandom};
                     r_data_i = data; r_resp_i = resp; r_valid_i = 1;
                     exp_prdata = lane_of(data, exp_paddr);
                  end
               end
            end

            if (aw_cnt == 1) since_aw++;
            aw_ready_i = cfg_fast ? 1'b1 : 1'($urandom % 2);
            ar_ready_i = cfg_fast ? 1'b1 : 1'($urandom % 2);
            if (cfg_w_wait >= 0)
               w_ready_i = (aw_cnt == 1 && since_aw > cfg_w_wait);
            else
               w_ready_i = cfg_fast ? 1'b1 : 1'($urandom % 2);

            aw_pend = aw_valid_o && !aw_ready_i;
            w_pend  = w_valid_o && !w_ready_i;
            ar_pend = ar_valid_o && !ar_ready_i;
            if (aw_valid_o && aw_ready_i) begin
               aw_cnt++; last_aw_addr = aw_addr_o;
            end
            if (w_valid_o && w_ready_i) begin
               w_cnt++; last_w_data = w_data_o; last_w_strb = w_strb_o;
            end
            if (ar_valid_o && ar_ready_i) ar_cnt++;
            if (b_valid_i && b_ready_o) begin resp_done = 1; b_fire = 1; end
            if (r_valid_i && r_ready_o) begin resp_done = 1; r_fire = 1; end
         end
      end
   end

   task automatic apb_start(input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input bit drop);
      txn_active = 1; exp_write = wr; exp_paddr = addr; exp_pwdata = wd;
      exp_no_pready = drop; exp_prdata = 0; exp_err = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; pready_cnt = 0; since_aw = 0;
      resp_done = 0;
      resp_wait = (cfg_resp_wait >= 0) ? cfg_resp_wait
                                       : int'($urandom_range(0, 3));
      PADDR = addr; PWDATA = wd; PWRITE = wr; PSEL = 1; PENABLE = 0;
      @(posedge clk); #1;
      PENABLE = 1;
   endtask

   // lat counts cycles from the setup cycle (as 1) to the PREADY cycle
   task automatic apb_finish(output int lat, output logic [31:0] rd,
                             output logic err);
      int n = 0;
      lat = 0; rd = 0; err = 0;
      while (!PREADY && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (!PREADY) begin
         chk("pready_timeout", PREADY, 1);
      end else begin
         rd = PRDATA; err = PSLVERR;
         @(posedge clk); #1;
         lat = n + 2;
         chk("pready_once", pready_cnt, 1);
      end
      PSEL = 0; PENABLE = 0; txn_active = 0;
   endtask

   task automatic apb_xfer(input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output logic err);
      apb_start(wr, addr, wd, 0);
      apb_finish(lat, rd, err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          lat, n;
      logic [31:0] rd;
      logic        err;
      rst_i = 1; PADDR = 0; PWDATA = 0; PWRITE = 0; PSEL = 0; PENABLE = 0;
      txn_active = 0; cfg_fast = 1; cfg_fixed = 1; cfg_resp = 0;
      cfg_rdata = 0; cfg_w_wait = -1; cfg_resp_wait = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {PRDATA, PSLVERR, PREADY, aw_valid_o, w_valid_o,
          ar_valid_o, b_ready_o, r_ready_o}, 0);
      rst_i = 0;
      @(posedge clk); #1;

      // minimum-latency write, upper lane
      apb_xfer(1, 32'h0000_0004, 32'hDEAD_BEEF, lat, rd, err);
      chk("wr_latency", lat, 4);
      chk("wr_aw_addr", last_aw_addr, 32'h4);
      chk("wr_strb", last_w_strb, 8'hF0);
      chk("wr_wdata", last_w_data, 64'hDEAD_BEEF_DEAD_BEEF);
      chk("wr_pslverr", err, 0);
      chk("wr_prdata", rd, 0);

      // reads with lane selection
      cfg_rdata = 64'h1111_2222_3333_4444;
      apb_xfer(0, 32'h0000_0000, 0, lat, rd, err);
      chk("rd0_latency", lat, 4);
      chk("rd0_data", rd, 32'h3333_4444);
      chk("rd0_err", err, 0);
      apb_xfer(0, 32'h0000_0008, 0, lat, rd, err);
      chk("rd8_data", rd, 32'h3333_4444);
      apb_xfer(0, 32'h0000_000C, 0, lat, rd, err);
      chk("rdC_data", rd, 32'h1111_2222);

      // W accepted well after AW
      cfg_w_wait = 5;
      apb_xfer(1, 32'h0000_0020, 32'h1234_5678, lat, rd, err);
      chk("wwait_slow", lat > 8, 1);
      chk("wwait_strb", last_w_strb, 8'h0F);
      chk("wwait_err", err, 0);
      cfg_w_wait = -1;

      // error response, then a clean one
      cfg_resp = 2'b10;
      apb_xfer(0, 32'h0000_0004, 0, lat, rd, err);
      chk("slverr_flag", err, 1);
      cfg_resp = 2'b00;
      apb_xfer(0, 32'h0000_0004, 0, lat, rd, err);
      chk("after_err_flag", err, 0);
      chk("after_err_data", rd, 32'h1111_2222);

      // PSEL abandoned: AXI side completes, no PREADY
      apb_start(0, 32'h0000_0010, 0, 1);
      @(posedge clk); #1;
      PSEL = 0; PENABLE = 0;
      n = 0;
      while (!resp_done && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk("drop_axi_done", resp_done, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("drop_no_pready", pready_cnt, 0);
      txn_active = 0;

      // reset while waiting for read data
      cfg_resp_wait = 50;
      apb_start(0, 32'h0000_0008, 0, 0);
      n = 0;
      while (!r_ready_o && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("reached_rd_resp", r_ready_o, 1);
      rst_i = 1; PSEL = 0; PENABLE = 0; txn_active = 0;
      @(posedge clk); #1;
      rst_i = 0;
      chk("rst_abort", {PRDATA, PSLVERR, PREADY, aw_valid_o, w_valid_o,
          ar_valid_o, b_ready_o, r_ready_o}, 0);
      cfg_resp_wait = 0;
      apb_xfer(0, 32'h0000_000C, 0, lat, rd, err);
      chk("post_rst_data", rd, 32'h1111_2222);
      chk("post_rst_latency", lat, 4);

      // randomized traffic
      cfg_fast = 0; cfg_fixed = 0; cfg_resp_wait = -1;
      for (int i = 0; i < 80; i++) begin
         apb_xfer(1'($urandom % 2), $urandom & 32'hFFFF_FFFC, $urandom,
                  lat, rd, err);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
